// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - command/status bundle between the decoder and the pc_sequencer
interface pc_sequencer_if #(
  parameter int AW     = 12,
  parameter int PHASES = 2,
  parameter int DEPTH  = 4
);
  localparam int PW = ($clog2(PHASES) > 1) ? $clog2(PHASES) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic          stall;
  logic          enable;
  logic          call;
  logic          ret;
  logic [AW-1:0] newaddr;
  logic [AW-1:0] addr;
  logic [PW-1:0] phase;
  logic          last_phase;
  logic [LW-1:0] stk_level;
  logic          stk_ovf;
  logic          stk_unf;

  modport master (
    output stall, enable, call, ret, newaddr,
    input  addr, phase, last_phase, stk_level, stk_ovf, stk_unf
  );

  modport slave (
    input  stall, enable, call, ret, newaddr,
    output addr, phase, last_phase, stk_level, stk_ovf, stk_unf
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - phased program counter with return stack (stack built when PC_STACK_EN is defined)
module pc_sequencer #(
  parameter int AW     = 12,
  parameter int PHASES = 2,
  parameter int DEPTH  = 4
) (
  input  logic         clk,
  input  logic         Rst,
  pc_sequencer_if.slave bus
);
  localparam int PW = ($clog2(PHASES) > 1) ? $clog2(PHASES) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LASTP = PW'(PHASES - 1);

  logic [AW-1:0] addr_q, addr_d, inc_addr;
  logic [PW-1:0] phase_q, phase_d;
  logic          last;

  assign inc_addr = addr_q + AW'(1);
  assign last     = (phase_q == LASTP);

`ifdef PC_STACK_EN
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [AW-1:0] stk_q [DEPTH];
  logic [LW-1:0] lvl_q, lvl_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          push, pop;

  // Shift-register LIFO: the top of stack always lives in entry 0
  always_ff @(posedge clk) begin
    if (push) begin
      stk_q[0] <= inc_addr;
      for (int i = 1; i < DEPTH; i++) stk_q[i] <= stk_q[i-1];
    end else if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) stk_q[i] <= stk_q[i+1];
    end
  end

  // Next-state: phase advance, and PC/stack update on the last-phase edge
  always_comb begin
    phase_d = phase_q;
    addr_d  = addr_q;
    lvl_d   = lvl_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (!bus.stall) begin
      phase_d = last ? '0 : phase_q + PW'(1);
      if (last) begin
        if (bus.ret) begin
          if (lvl_q != '0) begin
            addr_d = stk_q[0];
            lvl_d  = lvl_q - LW'(1);
            pop    = 1'b1;
          end else begin
            unf_d  = 1'b1;
            addr_d = inc_addr;
          end
        end else if (bus.call) begin
          addr_d = bus.newaddr;
          if (lvl_q != FULL) begin
            push  = 1'b1;
            lvl_d = lvl_q + LW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else if (bus.enable) begin
          addr_d = bus.newaddr;
        end else begin
          addr_d = inc_addr;
        end
      end
    end
  end

  // Stack level and sticky error flags
  always_ff @(posedge clk) begin
    if (!Rst) begin
      lvl_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.stk_level = lvl_q;
  assign bus.stk_ovf   = ovf_q;
  assign bus.stk_unf   = unf_q;
`else
  logic unused_ret;
  assign unused_ret = bus.ret;

  // Next-state without a stack: call degenerates to a plain jump, ret is ignored
  always_comb begin
    phase_d = phase_q;
    addr_d  = addr_q;
    if (!bus.stall) begin
      phase_d = last ? '0 : phase_q + PW'(1);
      if (last) begin
        if (bus.call || bus.enable) addr_d = bus.newaddr;
        else                        addr_d = inc_addr;
      end
    end
  end

  assign bus.stk_level = '0;
  assign bus.stk_ovf   = 1'b0;
  assign bus.stk_unf   = 1'b0;
`endif

  // PC and phase registers; reset wins over stall and every command
  always_ff @(posedge clk) begin
    if (!Rst) begin
      addr_q  <= '0;
      phase_q <= '0;
    end else begin
      addr_q  <= addr_d;
      phase_q <= phase_d;
    end
  end

  assign bus.addr       = addr_q;
  assign bus.phase      = phase_q;
  assign bus.last_phase = last;
endmodule
